// File: rtl/muldiv_seq_if.sv
// EX-stage handshake bundle between the pipeline and the sequential RV32M multiply/divide unit.
interface muldiv_seq_if;
    logic        StartE;
    logic [2:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] MDResultE;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, FlushE,
        input  BusyE, DoneE, MDResultE
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, FlushE,
        output BusyE, DoneE, MDResultE
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV32M unit: 32-cycle shift-add multiply / restoring divide on magnitudes, sign-fixed in DONE.
// Optional MULDIV_EARLY_OUT_EN resolves divide-by-zero, signed overflow and zero multiplies in one RUN cycle.
module muldiv_seq (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [2:0]  op_q;
    logic [31:0] opnd_q, hi_q, lo_q, result_q;
    logic [4:0]  cnt_q;
    logic        neg_q, rneg_q;
`ifdef MULDIV_EARLY_OUT_EN
    logic        early_q;
    logic        early;
`endif

    logic        start, is_div, a_signed, b_signed, sa, sb;
    logic [31:0] a_mag, b_mag, hi_init, lo_init;

    always_comb begin
        start    = (state_q == StIdle) && bus.StartE && !bus.FlushE;
        is_div   = bus.OpE[2];
        a_signed = (bus.OpE == 3'd1) || (bus.OpE == 3'd2) || (bus.OpE == 3'd4) || (bus.OpE == 3'd6);
        b_signed = (bus.OpE == 3'd1) || (bus.OpE == 3'd4) || (bus.OpE == 3'd6);
        sa       = a_signed & bus.SrcAE[31];
        sb       = b_signed & bus.SrcBE[31];
        a_mag    = sa ? -bus.SrcAE : bus.SrcAE;
        b_mag    = sb ? -bus.SrcBE : bus.SrcBE;
        hi_init  = '0;
        lo_init  = is_div ? a_mag : b_mag;
`ifdef MULDIV_EARLY_OUT_EN
        // Preload the accumulators with the final magnitudes the full iteration would reach.
        early = 1'b0;
        if (is_div) begin
            if (bus.SrcBE == '0) begin
                early   = 1'b1;
                hi_init = a_mag;
                lo_init = '1;
            end else if (!bus.OpE[0] && bus.SrcAE == 32'h8000_0000 && bus.SrcBE == '1) begin
                early   = 1'b1;
                lo_init = 32'h8000_0000;
            end
        end else if (bus.SrcAE == '0 || bus.SrcBE == '0) begin
            early   = 1'b1;
            lo_init = '0;
        end
`endif
    end

    logic [32:0] mul_sum, div_shift;
    logic [31:0] div_sub;
    logic        div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : 32'd0)};
        div_shift = {hi_q, lo_q[31]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[31:0] - opnd_q;
    end

    logic [63:0] prod;
    logic [31:0] quo, rem, final_res;

    always_comb begin
        prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo  = neg_q ? -lo_q : lo_q;
        rem  = rneg_q ? -hi_q : hi_q;
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
        end else begin
            final_res = op_q[1] ? rem : quo;
        end
    end

    assign bus.BusyE     = start || (state_q == StRun);
    assign bus.DoneE     = (state_q == StDone) && !bus.FlushE;
    assign bus.MDResultE = bus.DoneE ? final_res : result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            early_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        op_q    <= bus.OpE;
                        opnd_q  <= is_div ? b_mag : a_mag;
                        hi_q    <= hi_init;
                        lo_q    <= lo_init;
                        cnt_q   <= 5'd31;
                        // Divide by zero must return all ones regardless of dividend sign.
                        neg_q   <= (sa ^ sb) & !(is_div && bus.SrcBE == '0);
                        rneg_q  <= sa;
`ifdef MULDIV_EARLY_OUT_EN
                        early_q <= early;
`endif
                    end
                end
                StRun: begin
                    if (bus.FlushE) begin
                        state_q <= StIdle;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (early_q) begin
                        state_q <= StDone;
`endif
                    end else begin
                        if (op_q[2]) begin
                            hi_q <= div_ge ? div_sub : div_shift[31:0];
                            lo_q <= {lo_q[30:0], div_ge};
                        end else begin
                            {hi_q, lo_q} <= {mul_sum, lo_q[31:1]};
                        end
                        cnt_q <= cnt_q - 5'd1;
                        if (cnt_q == 5'd0) state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!bus.FlushE) result_q <= final_res;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus random bench for muldiv_seq; expected results queued at start, compared at DoneE.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          cur_lat;
    logic        bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ae, be, p;
        int          sa_i, sb_i;
        logic [31:0] r;
        ae   = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        be   = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p    = ae * be;
        sa_i = a;
        sb_i = b;
        case (op)
            3'd0: r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa_i / sb_i);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa_i % sb_i);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic e;
        int   early_lat;
        early_lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
        early_lat = 2;
`endif
        if (op[2]) e = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else       e = (a == 0) || (b == 0);
        return e ? early_lat : 33;
    endfunction

    // Called at a falling edge; the following rising edge is the start cycle t.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv);
        bus.StartE = 1'b1;
        bus.OpE    = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        #1;
        check("busy_start", 32'(bus.BusyE), 32'd1);
        exp_q.push_back(expv);
        cur_lat = exp_lat(op, a, b);
    endtask

    task automatic finish_op(input string tag);
        int          seen;
        logic        busy_bad;
        logic [31:0] e;
        seen     = 0;
        busy_bad = 1'b0;
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        bus.OpE    = 3'($urandom);
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.DoneE) begin
                seen = n;
                break;
            end
            if (!bus.BusyE) busy_bad = 1'b1;
        end
        check({tag, "_latency"}, 32'(seen), 32'(cur_lat));
        check({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
        e = exp_q.pop_front();
        if (seen != 0) begin
            check({tag, "_busy_done"}, 32'(bus.BusyE), 32'd0);
            check({tag, "_result"}, bus.MDResultE, e);
            last_res = e;
            @(negedge clk);
            check({tag, "_hold"}, bus.MDResultE, last_res);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string tag);
        @(negedge clk);
        start_op(op, a, b, expv);
        finish_op(tag);
    endtask

    initial begin
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        bus.OpE    = '0;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        last_res   = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_busy", 32'(bus.BusyE), 32'd0);
        check("rst_done", 32'(bus.DoneE), 32'd0);
        check("rst_result", bus.MDResultE, 32'd0);

        // First start right as reset releases.
        @(negedge clk);
        reset = 1'b0;
        start_op(3'd0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6);
        finish_op("mul");

        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg");
        do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "divu_big");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_zero");
        do_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_zero");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_zero_neg");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_zero_neg");
        do_op(3'd0, 32'd0, 32'h1234_5678, 32'd0, "mul_zero");

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : $urandom;
            do_op(op, a, b, ref_md(op, a, b), "rand");
        end

        // Flush mid-RUN at t+10, restart at t+11.
        @(negedge clk);
        start_op(3'd0, 32'd3, 32'd5, 32'd15);
        @(posedge clk);
        #1 bus.StartE = 1'b0;
        bad = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.DoneE) bad = 1'b1;
            if (n == 10) bus.FlushE = 1'b1;
        end
        @(negedge clk);
        bus.FlushE = 1'b0;
        check("flush_run_nodone", 32'(bad), 32'd0);
        check("flush_run_idle", 32'(bus.BusyE), 32'd0);
        check("flush_run_result", bus.MDResultE, last_res);
        void'(exp_q.pop_front());
        start_op(3'd5, 32'd1000, 32'd10, 32'd100);
        finish_op("flush_restart");

        // Flush landing on the DONE cycle.
        @(negedge clk);
        start_op(3'd0, 32'd3, 32'd5, 32'd15);
        @(posedge clk);
        #1 bus.StartE = 1'b0;
        bad = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (bus.DoneE) bad = 1'b1;
        end
        @(negedge clk);
        bus.FlushE = 1'b1;
        #1;
        check("flush_done_early", 32'(bad), 32'd0);
        check("flush_done_pulse", 32'(bus.DoneE), 32'd0);
        check("flush_done_result", bus.MDResultE, last_res);
        @(negedge clk);
        bus.FlushE = 1'b0;
        check("flush_done_after", bus.MDResultE, last_res);
        check("flush_done_busy", 32'(bus.BusyE), 32'd0);
        void'(exp_q.pop_front());

        // Asynchronous reset mid-RUN at t+5.
        @(negedge clk);
        start_op(3'd5, 32'd1000, 32'd3, 32'd333);
        @(posedge clk);
        #1 bus.StartE = 1'b0;
        for (int n = 1; n <= 5; n++) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_run_busy", 32'(bus.BusyE), 32'd0);
        check("rst_run_done", 32'(bus.DoneE), 32'd0);
        check("rst_run_result", bus.MDResultE, 32'd0);
        exp_q.delete();
        last_res = '0;
        @(negedge clk);
        reset = 1'b0;
        start_op(3'd5, 32'd100, 32'd7, 32'd14);
        finish_op("post_rst_divu");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: StartE  input  1  ID/EX register holds a valid RV32M op.
REQ-004 SHALL have port: OpE  input  3  funct3 of the op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have port: SrcAE  input  32  forwarded rs1 operand.
REQ-006 SHALL have port: SrcBE  input  32  forwarded rs2 operand.
REQ-007 SHALL have port: FlushE  input  1  EX stage flush from the hazard unit.
REQ-008 SHALL have port: BusyE  output  1  stall request for the F, D and E stages.
REQ-009 SHALL have port: DoneE  output  1  one-cycle pulse; MDResultE valid.
REQ-010 SHALL have port: MDResultE  output  32  result for the EX/MEM ALUResult mux.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE & StartE & !FlushE: SHALL latch OpE, SrcAE and SrcBE, latch operand signs per op, store operand magnitudes, load the 5-bit counter with 31, and go to RUN.
REQ-013 RUN: SHALL process one bit per cycle (shift-add multiply, restoring divide) and decrement the counter; at counter==0 SHALL go to DONE.
REQ-014 DONE: SHALL assert DoneE, apply sign correction, update MDResultE, and return to IDLE; StartE SHALL be ignored in DONE.
REQ-015 BusyE SHALL equal (IDLE & StartE & !FlushE) | RUN; BusyE SHALL be low in DONE so the op leaves EX that cycle.
REQ-016 Latency: StartE sampled in cycle t SHALL give DoneE in cycle t+33; back-to-back ops SHALL start no earlier than the cycle after DONE.
REQ-017 MUL SHALL return low 32 bits of the 64-bit product; MULH/MULHSU/MULHU SHALL return the high 32 bits with signed×signed, signed×unsigned, unsigned×unsigned operands.
REQ-018 DIV/REM signed: quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned ops.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-021 FlushE in RUN or DONE SHALL force IDLE next edge; DoneE SHALL NOT assert for the flushed op and MDResultE SHALL be unchanged.
REQ-022 MDResultE SHALL hold its last value between DONE cycles.
REQ-023 Operand inputs SHALL be ignored outside the IDLE start cycle, so forwarding changes mid-run have no effect.

Reset
REQ-024 reset SHALL asynchronously force IDLE, counter 0, operand and accumulator registers 0, and MDResultE 0.
REQ-025 During reset, BusyE and DoneE SHALL be 0; an op in progress SHALL be abandoned without DoneE.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MULDIV_EARLY_OUT_EN, when defined, SHALL resolve these cases in one RUN cycle (DoneE at t+2): divide by zero, signed overflow, and multiply with either operand 0.
REQ-028 Results in early-out cases SHALL be identical to the full-latency results.
REQ-029 Without MULDIV_EARLY_OUT_EN, every op SHALL take exactly t+33, and no early-out comparator logic SHALL be present.

Verification
REQ-030 MUL, SrcAE=7, SrcBE=0xFFFFFFFA (-6) -> BusyE high t..t+32, DoneE at t+33, MDResultE=0xFFFFFFD6.
REQ-031 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/0xFFFFFFFF -> 0; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. With MULDIV_EARLY_OUT_EN, DoneE at t+2; without it, at t+33.
REQ-034 FlushE asserted at t+10 -> IDLE at t+11, no DoneE, MDResultE unchanged; a new StartE at t+11 -> DoneE at t+44.
REQ-035 reset asserted mid-RUN at t+5 -> BusyE=0 and MDResultE=0 immediately, with no clock edge needed; after release, DIVU 100/7 -> 14.
